// File: rtl/riscv_trace_buffer.sv
// Retired-instruction trace buffer: arm/trigger-gated capture into a DEPTH-entry FIFO,
// stop-on-full or circular mode, valid/ready drain port and a saturating lost-record counter.
module riscv_trace_buffer #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned IWIDTH = 32,
    parameter int unsigned CWIDTH = 16,
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNTW   = 16
) (
    input  logic                       i_riscv_clk,
    input  logic                       i_riscv_rst,
    input  logic                       i_riscv_trc_valid,
    input  logic [IWIDTH-1:0]          i_riscv_trc_inst,
    input  logic [CWIDTH-1:0]          i_riscv_trc_cinst,
    input  logic [AWIDTH-1:0]          i_riscv_trc_rdaddr,
    input  logic [DWIDTH-1:0]          i_riscv_trc_memaddr,
    input  logic [DWIDTH-1:0]          i_riscv_trc_pc,
    input  logic [DWIDTH-1:0]          i_riscv_trc_store,
    input  logic [DWIDTH-1:0]          i_riscv_trc_rddata,
    input  logic                       i_riscv_trc_arm,
    input  logic                       i_riscv_trc_stop,
    input  logic                       i_riscv_trc_flush,
    input  logic                       i_riscv_trc_mode,
    input  logic                       i_riscv_trc_trigen,
    input  logic [DWIDTH-1:0]          i_riscv_trc_trigpc,
    input  logic                       i_riscv_trc_ready,
    output logic                       o_riscv_trc_valid,
    output logic [IWIDTH-1:0]          o_riscv_trc_inst,
    output logic [CWIDTH-1:0]          o_riscv_trc_cinst,
    output logic [AWIDTH-1:0]          o_riscv_trc_rdaddr,
    output logic [DWIDTH-1:0]          o_riscv_trc_memaddr,
    output logic [DWIDTH-1:0]          o_riscv_trc_pc,
    output logic [DWIDTH-1:0]          o_riscv_trc_store,
    output logic [DWIDTH-1:0]          o_riscv_trc_rddata,
    output logic [1:0]                 o_riscv_trc_state,
    output logic [$clog2(DEPTH):0]     o_riscv_trc_count,
    output logic [CNTW-1:0]            o_riscv_trc_lost
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = IWIDTH + CWIDTH + AWIDTH + 4 * DWIDTH;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StArmed   = 2'b01,
        StCapture = 2'b10,
        StDone    = 2'b11
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [RW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_d;
    logic [CNTW-1:0] r_lost;

    logic          w_hit;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_ovw;
    logic          w_drop;
    logic [RW-1:0] w_rec;
    logic [RW-1:0] w_head;

    assign w_rec = {i_riscv_trc_inst, i_riscv_trc_cinst, i_riscv_trc_rdaddr, i_riscv_trc_memaddr,
                    i_riscv_trc_pc, i_riscv_trc_store, i_riscv_trc_rddata};

    always_comb begin
        w_hit  = i_riscv_trc_valid && (!i_riscv_trc_trigen || (i_riscv_trc_pc == i_riscv_trc_trigpc));
        w_push = !i_riscv_trc_flush && !i_riscv_trc_stop &&
                 (((r_state == StArmed) && w_hit) || ((r_state == StCapture) && i_riscv_trc_valid));
        w_pop  = !i_riscv_trc_flush && (r_count != '0) && i_riscv_trc_ready;
        w_full = (r_count == CW'(DEPTH));
        w_wr   = w_push && (!w_full || w_pop || i_riscv_trc_mode);
        w_ovw  = w_push && w_full && !w_pop && i_riscv_trc_mode;
        w_drop = w_push && w_full && !w_pop && !i_riscv_trc_mode;

        // Overwrite advances both pointers, so it counts as a write plus a read.
        w_count_d = r_count;
        if (w_wr && !(w_pop || w_ovw)) begin
            w_count_d = r_count + CW'(1);
        end else if (!w_wr && w_pop) begin
            w_count_d = r_count - CW'(1);
        end

        w_state_d = r_state;
        if (i_riscv_trc_stop) begin
            if ((r_state == StArmed) || (r_state == StCapture)) begin
                w_state_d = StDone;
            end
        end else if (i_riscv_trc_arm && ((r_state == StIdle) || (r_state == StDone))) begin
            w_state_d = StArmed;
        end else if (w_push) begin
            if (r_state == StArmed) begin
                w_state_d = StCapture;
            end
            if (w_drop || (!i_riscv_trc_mode && (w_count_d == CW'(DEPTH)))) begin
                w_state_d = StDone;
            end
        end
    end

    always_ff @(posedge i_riscv_clk) begin
        if (i_riscv_rst) begin
            r_state <= StIdle;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_lost  <= '0;
        end else begin
            r_state <= w_state_d;
            if (i_riscv_trc_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_lost  <= '0;
            end else begin
                if (w_wr) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop || w_ovw) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                r_count <= w_count_d;
                if ((w_ovw || w_drop) && (r_lost != '1)) begin
                    r_lost <= r_lost + CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_riscv_clk) begin
        if (!i_riscv_rst && w_wr) begin
            r_mem[r_wptr] <= w_rec;
        end
    end

    assign w_head = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign {o_riscv_trc_inst, o_riscv_trc_cinst, o_riscv_trc_rdaddr, o_riscv_trc_memaddr,
            o_riscv_trc_pc, o_riscv_trc_store, o_riscv_trc_rddata} = w_head;

    assign o_riscv_trc_valid = (r_count != '0);
    assign o_riscv_trc_state = r_state;
    assign o_riscv_trc_count = r_count;
    assign o_riscv_trc_lost  = r_lost;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer (DEPTH=4) with a pc-keyed scoreboard of captured records.
module tb_riscv_trace_buffer;

    localparam int unsigned DW = 64;
    localparam int unsigned DEP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          v_in;
    logic [31:0]   inst_in;
    logic [15:0]   cinst_in;
    logic [4:0]    rd_in;
    logic [DW-1:0] mem_in, pc_in, st_in, rdd_in;
    logic          arm, stop, flush, mode, trigen, ready;
    logic [DW-1:0] trigpc;
    logic          v_out;
    logic [31:0]   inst_out;
    logic [15:0]   cinst_out;
    logic [4:0]    rd_out;
    logic [DW-1:0] mem_out, pc_out, st_out, rdd_out;
    logic [1:0]    state;
    logic [2:0]    count;
    logic [15:0]   lost;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q[$];
    int exp_lost = 0;

    always #5 clk = ~clk;

    riscv_trace_buffer #(.DEPTH(DEP)) dut (
        .i_riscv_clk(clk), .i_riscv_rst(rst), .i_riscv_trc_valid(v_in),
        .i_riscv_trc_inst(inst_in), .i_riscv_trc_cinst(cinst_in), .i_riscv_trc_rdaddr(rd_in),
        .i_riscv_trc_memaddr(mem_in), .i_riscv_trc_pc(pc_in), .i_riscv_trc_store(st_in),
        .i_riscv_trc_rddata(rdd_in), .i_riscv_trc_arm(arm), .i_riscv_trc_stop(stop),
        .i_riscv_trc_flush(flush), .i_riscv_trc_mode(mode), .i_riscv_trc_trigen(trigen),
        .i_riscv_trc_trigpc(trigpc), .i_riscv_trc_ready(ready), .o_riscv_trc_valid(v_out),
        .o_riscv_trc_inst(inst_out), .o_riscv_trc_cinst(cinst_out), .o_riscv_trc_rdaddr(rd_out),
        .o_riscv_trc_memaddr(mem_out), .o_riscv_trc_pc(pc_out), .o_riscv_trc_store(st_out),
        .o_riscv_trc_rddata(rdd_out), .o_riscv_trc_state(state), .o_riscv_trc_count(count),
        .o_riscv_trc_lost(lost)
    );

    function automatic logic [31:0] f_inst(input logic [DW-1:0] pc);
        return pc[31:0] ^ 32'h1357_9BDF;
    endfunction
    function automatic logic [15:0] f_cinst(input logic [DW-1:0] pc);
        return pc[15:0] ^ 16'hC0DE;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [DW-1:0] pc);
        v_in     = 1'b1;
        pc_in    = pc;
        inst_in  = f_inst(pc);
        cinst_in = f_cinst(pc);
        rd_in    = pc[6:2];
        mem_in   = pc + 64'h1000;
        st_in    = ~pc;
        rdd_in   = pc * 3;
    endtask

    // cap: record is expected to enter the capture path; the model handles full-FIFO policy.
    task automatic drive_rec(input logic [DW-1:0] pc, input bit cap);
        set_rec(pc);
        if (cap) begin
            if (q.size() == DEP) begin
                exp_lost++;
                if (mode) begin
                    void'(q.pop_front());
                    q.push_back(pc);
                end
            end else begin
                q.push_back(pc);
            end
        end
        tick();
        v_in = 1'b0;
    endtask

    task automatic drain(input int n);
        logic [DW-1:0] e;
        ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL drain_underflow: observed empty scoreboard expected entry");
            end else begin
                e = q.pop_front();
                check("drain_valid", DW'(v_out), 64'd1);
                check("drain_pc", pc_out, e);
                check("drain_inst", DW'(inst_out), DW'(f_inst(e)));
                check("drain_cinst", DW'(cinst_out), DW'(f_cinst(e)));
                check("drain_rdaddr", DW'(rd_out), DW'(e[6:2]));
                check("drain_memaddr", mem_out, e + 64'h1000);
                check("drain_store", st_out, ~e);
                check("drain_rddata", rdd_out, e * 3);
            end
            tick();
        end
        ready = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; v_in = 1'b0; arm = 1'b0; stop = 1'b0; flush = 1'b0; mode = 1'b0;
        trigen = 1'b0; trigpc = '0; ready = 1'b0;
        set_rec('0);
        v_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_state", DW'(state), 64'd0);
        check("rst_count", DW'(count), 64'd0);
        check("rst_valid", DW'(v_out), 64'd0);
        check("rst_lost", DW'(lost), 64'd0);
        check("rst_pc", pc_out, 64'd0);

        // 1: free-running capture, then ordered drain
        pulse_arm();
        check("t1_armed", DW'(state), 64'd1);
        drive_rec(64'h100, 1'b1);
        drive_rec(64'h104, 1'b1);
        drive_rec(64'h108, 1'b1);
        check("t1_state", DW'(state), 64'd2);
        check("t1_count", DW'(count), 64'd3);
        drain(3);
        check("t1_valid_drop", DW'(v_out), 64'd0);

        // 2: pc trigger
        pulse_stop();
        check("t2_done", DW'(state), 64'd3);
        trigen = 1'b1;
        trigpc = 64'h200;
        pulse_arm();
        drive_rec(64'h1F8, 1'b0);
        drive_rec(64'h1FC, 1'b0);
        check("t2_still_armed", DW'(state), 64'd1);
        check("t2_empty", DW'(count), 64'd0);
        drive_rec(64'h200, 1'b1);
        check("t2_capture", DW'(state), 64'd2);
        drive_rec(64'h204, 1'b1);
        check("t2_count", DW'(count), 64'd2);
        drain(2);

        // 3: stop-on-full, then drop after rearm
        pulse_stop();
        trigen = 1'b0;
        pulse_arm();
        drive_rec(64'h0, 1'b1);
        drive_rec(64'h4, 1'b1);
        drive_rec(64'h8, 1'b1);
        check("t3_capture", DW'(state), 64'd2);
        drive_rec(64'hC, 1'b1);
        check("t3_done", DW'(state), 64'd3);
        check("t3_count", DW'(count), 64'd4);
        check("t3_lost0", DW'(lost), DW'(exp_lost));
        pulse_arm();
        check("t3_rearmed", DW'(state), 64'd1);
        drive_rec(64'h10, 1'b1);
        check("t3_lost1", DW'(lost), DW'(exp_lost));
        check("t3_done2", DW'(state), 64'd3);
        check("t3_count_full", DW'(count), 64'd4);
        drain(4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_lost = 0;
        check("t3_flush_lost", DW'(lost), 64'd0);

        // 4: circular overwrite
        mode = 1'b1;
        pulse_arm();
        for (int i = 0; i < 6; i++) drive_rec(DW'(4 * i), 1'b1);
        check("t4_count", DW'(count), 64'd4);
        check("t4_lost", DW'(lost), DW'(exp_lost));
        check("t4_state", DW'(state), 64'd2);
        drain(4);
        for (int i = 0; i < 4; i++) drive_rec(DW'(64'h20 + 4 * i), 1'b1);
        check("t4_refill", DW'(count), 64'd4);

        // 5: full with simultaneous push and pop, then flush+stop
        ready = 1'b1;
        set_rec(64'h30);
        check("t5_head", pc_out, q.pop_front());
        q.push_back(64'h30);
        tick();
        v_in = 1'b0;
        ready = 1'b0;
        check("t5_count", DW'(count), 64'd4);
        check("t5_lost", DW'(lost), DW'(exp_lost));
        check("t5_new_head", pc_out, q[0]);
        flush = 1'b1;
        stop = 1'b1;
        tick();
        flush = 1'b0;
        stop = 1'b0;
        q.delete();
        exp_lost = 0;
        check("t5_fl_count", DW'(count), 64'd0);
        check("t5_fl_lost", DW'(lost), 64'd0);
        check("t5_fl_state", DW'(state), 64'd3);
        check("t5_fl_valid", DW'(v_out), 64'd0);

        // 6: reset mid-capture beats a concurrent record
        mode = 1'b0;
        pulse_arm();
        drive_rec(64'h40, 1'b1);
        drive_rec(64'h44, 1'b1);
        drive_rec(64'h48, 1'b1);
        check("t6_count", DW'(count), 64'd3);
        rst = 1'b1;
        set_rec(64'h4C);
        tick();
        rst = 1'b0;
        v_in = 1'b0;
        check("t6_state", DW'(state), 64'd0);
        check("t6_count0", DW'(count), 64'd0);
        check("t6_valid", DW'(v_out), 64'd0);
        check("t6_pc", pc_out, 64'd0);
        check("t6_inst", DW'(inst_out), 64'd0);
        check("t6_cinst", DW'(cinst_out), 64'd0);
        check("t6_rdaddr", DW'(rd_out), 64'd0);
        check("t6_memaddr", mem_out, 64'd0);
        check("t6_store", st_out, 64'd0);
        check("t6_rddata", rdd_out, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
